// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: address decode, registered LED strobe, switch sync/debounce, load mux.
// Optional error tracking is enabled by defining IO_BRIDGE_ERR_EN.
module io_bridge #(
  parameter logic [21:0] IO_BASE         = 22'h3FFFFF,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] switch,
  output logic [31:0] rdata,
  output logic        ledcs,
  output logic [1:0]  ledaddr,
  output logic [15:0] ledwdata,
  output logic        io_err
);

  localparam logic [7:0]       OFF_LED_LO = 8'h60;
  localparam logic [7:0]       OFF_LED_HI = 8'h62;
  localparam logic [7:0]       OFF_SW     = 8'h70;
  localparam logic [7:0]       OFF_STAT   = 8'h74;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_io_hit;
  logic [7:0]       w_off;
  logic             w_rd;
  logic             w_led_off;
  logic             w_led_wr;
  logic             w_stat_rd;
  logic             w_accept;
  logic             w_err;
  logic             w_unused_bits;

  logic             r_ledcs;
  logic [1:0]       r_ledaddr;
  logic [15:0]      r_ledwdata;
  logic [15:0]      r_sync1;
  logic [15:0]      r_sync2;
  logic [15:0]      r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_changed;

  // A simultaneous read and write is treated purely as a write.
  assign w_io_hit      = (addr[31:10] == IO_BASE);
  assign w_off         = addr[7:0];
  assign w_rd          = mem_read & ~mem_write;
  assign w_led_off     = (w_off == OFF_LED_LO) | (w_off == OFF_LED_HI);
  assign w_led_wr      = mem_write & w_io_hit & w_led_off;
  assign w_stat_rd     = w_rd & w_io_hit & (w_off == OFF_STAT);
  assign w_accept      = (r_sync2 != r_deb) && (r_cnt == CNT_MAX);
  assign w_unused_bits = ^{addr[9:8], wdata[31:16]};

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ledcs    <= 1'b0;
      r_ledaddr  <= 2'b00;
      r_ledwdata <= 16'h0000;
    end else begin
      r_ledcs <= w_led_wr;
      if (w_led_wr) begin
        r_ledaddr  <= addr[1:0];
        r_ledwdata <= wdata[15:0];
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 16'h0000;
      r_sync2 <= 16'h0000;
    end else begin
      r_sync1 <= switch;
      r_sync2 <= r_sync1;
    end
  end

  // Whole-vector debounce: any return to the accepted value restarts the count.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= 16'h0000;
      r_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else if (w_accept) begin
      r_changed <= 1'b1;
    end else if (w_stat_rd) begin
      r_changed <= 1'b0;
    end
  end

`ifdef IO_BRIDGE_ERR_EN
  logic w_unmapped;
  logic w_err_evt;
  logic r_io_err;

  assign w_unmapped = ~(w_led_off | (w_off == OFF_SW) | (w_off == OFF_STAT));
  assign w_err_evt  = w_io_hit & (mem_read | mem_write) & (w_unmapped | (w_rd & w_led_off));

  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_err <= 1'b0;
    end else if (w_err_evt) begin
      r_io_err <= 1'b1;
    end
  end

  assign w_err = r_io_err;
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    rdata = 32'h0000_0000;
    if (w_rd) begin
      if (!w_io_hit) begin
        rdata = mem_rdata;
      end else if (w_off == OFF_SW) begin
        rdata = {16'h0000, r_deb};
      end else if (w_off == OFF_STAT) begin
        rdata = {30'h0, w_err, r_changed};
      end
    end
  end

  assign ledcs    = r_ledcs;
  assign ledaddr  = r_ledaddr;
  assign ledwdata = r_ledwdata;
  assign io_err   = w_err;

endmodule
